shift_feeder: RTL
=================

# shift_feeder

Upstream sequencer for the 4-bit right-shift register (ports clk, areset, load, ena, data, q). It buffers parallel words from a valid/ready producer in a small FIFO and drives the register's load/ena/data controls. It samples the register's LSB to emit each word as a serial LSB-first bit stream with valid/ready and last markers. One word occupies the register for exactly WIDTH bit-transfer cycles, and the next word's load overlaps the last bit so back-to-back words stream without gaps.

## Interface
- WIDTH, 4: word width; matches the shift register width.
- DEPTH, 4: FIFO entries; must be a power of two and at least 2.
- clk  input  1  rising-edge clock, shared with the shift register.
- areset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_data  input  WIDTH  parallel word from the producer.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  FIFO can accept a word; equals !full; forced 0 while areset is low.
- sr_load  output  1  drives the shift register's load input.
- sr_ena  output  1  drives the shift register's ena input.
- sr_data  output  WIDTH  drives the shift register's data input; equals the FIFO head word.
- sr_q0  input  1  q[0] of the shift register.
- bit_out  output  1  serial bit; equals sr_q0 when bit_valid is 1, otherwise 0.
- bit_valid  output  1  bit_out carries a bit.
- bit_last  output  1  the current bit is bit WIDTH-1 of its word.
- bit_ready  input  1  downstream accepts bit_out this cycle.
- busy  output  1  high when state is SHIFT or the FIFO is non-empty.

## Operation
- Shift register contract relied on:
  - load has priority over ena.
  - load: q <= data at the next edge.
  - ena: q <= {1'b0, q[WIDTH-1:1]} at the next edge.
- FIFO:
  - push when in_valid && in_ready.
  - pop exactly when sr_load is 1.
  - No bypass: a word pushed into an empty FIFO can be popped at the earliest on the next cycle.
  - A pop on a full FIFO frees the slot at the next edge. in_ready stays 0 during that cycle.
  - Pointers wrap modulo DEPTH; the occupancy counter is $clog2(DEPTH)+1 bits wide.
- FSM has two states, IDLE and SHIFT, plus a bit index k (0..WIDTH-1).
- IDLE:
  - sr_load = !empty.
  - If sr_load, go to SHIFT with k=0.
- SHIFT:
  - bit_valid = 1; bit_out = sr_q0; bit_last = (k == WIDTH-1).
  - A transfer occurs when bit_valid && bit_ready.
  - Transfer with k < WIDTH-1: sr_ena = 1, k <= k+1.
  - Transfer with k == WIDTH-1 and FIFO non-empty: sr_load = 1 (pop), k <= 0, stay in SHIFT.
  - Transfer with k == WIDTH-1 and FIFO empty: go to IDLE, k <= 0.
  - No transfer (bit_ready = 0): sr_load = 0, sr_ena = 0, k holds, register contents hold.
- sr_ena and sr_load are never both 1 in the same cycle.
- sr_load, sr_ena, bit_valid, bit_last, bit_out, in_ready and busy are combinational from state, k, FIFO flags and the inputs. They carry no registered delay.
- Reset (areset low at an edge):
  - state <= IDLE, k <= 0, FIFO pointers and count <= 0.
  - After the edge: sr_load = 0, sr_ena = 0, bit_valid = 0, bit_last = 0, bit_out = 0, busy = 0.
  - in_ready = 0 while areset is low and 1 once it is high again.
  - Reset mid-word: the word in flight and all FIFO contents are discarded without a bit_last. The shift register is not cleared by this block.

## Timing
- Word accepted at edge of cycle A into an idle, empty block:
  - sr_load = 1 in cycle A+1.
  - First bit_valid in cycle A+2.
  - With bit_ready held at 1, bits 0..WIDTH-1 appear in cycles A+2..A+1+WIDTH; bit_last is in cycle A+1+WIDTH.
- Sustained throughput: one bit per cycle. Consecutive words need no idle cycle between bit_last and the next bit 0.
- A stall of n cycles extends the word by exactly n cycles. bit_out holds its value during the stall.
- FIFO capacity: DEPTH words queued plus one word resident in the shift register.

## Test plan
- Idle, bit_ready = 1; push 4'b0110 at cycle A:
  - sr_load = 1 and sr_data = 0110 in cycle A+1.
  - bit_out 0,1,1,0 in cycles A+2..A+5; bit_last only in A+5.
  - busy = 0 from cycle A+6.
- Push 4'h6 then 4'h9 on consecutive cycles:
  - bits 0,1,1,0,1,0,0,1 appear contiguously.
  - The second sr_load coincides with the first word's bit_last cycle.
  - No cycle with both sr_load and sr_ena high.
- Word 4'b1011 with bit_ready low for 3 cycles while k = 1:
  - bit_out stays 1 and sr_ena stays 0 for those 3 cycles.
  - The sequence then resumes as 1,1,0,1 overall; total 7 bit_valid cycles.
- bit_ready = 0, push 6 words back-to-back:
  - word 1 is loaded.
  - words 2..5 fill the FIFO.
  - in_ready = 0 when word 6 is offered, so word 6 is not accepted.
  - After bit_ready returns to 1, exactly 5 words are serialized in order.
- areset low during bit 2 of a word with 2 words queued:
  - next cycle bit_valid = 0, busy = 0, in_ready = 0.
  - After release, in_ready = 1 and a new word 4'b0001 serializes as 1,0,0,0.

Source files
------------

// File: rtl/shift_feeder.sv
// shift_feeder: FIFO-buffered sequencer that loads a WIDTH-bit right-shift
// register and streams its LSB out as a serial valid/ready/last bit stream.
module shift_feeder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sr_load,
  output logic             sr_ena,
  output logic [WIDTH-1:0] sr_data,
  input  logic             sr_q0,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_last,
  input  logic             bit_ready,
  output logic             busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             empty, full, push, pop;

  // FIFO flags; pops are driven only by a register load, so there is no bypass
  assign empty    = (count == '0);
  assign full     = (count == C_FULL);
  assign in_ready = areset && !full;
  assign push     = in_valid && in_ready;
  assign pop      = sr_load;
  assign sr_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state and bit-index register
  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state and register controls; the next load overlaps the last bit
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    sr_load   = 1'b0;
    sr_ena    = 1'b0;
    bit_valid = 1'b0;
    bit_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          sr_load = 1'b1;
          state_d = SHIFT;
          k_d     = '0;
        end
      end
      SHIFT: begin
        bit_valid = 1'b1;
        bit_last  = (k_q == K_LAST);
        if (bit_ready) begin
          if (k_q != K_LAST) begin
            sr_ena = 1'b1;
            k_d    = k_q + KW'(1);
          end else if (!empty) begin
            sr_load = 1'b1;
            k_d     = '0;
          end else begin
            state_d = IDLE;
            k_d     = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  assign bit_out = bit_valid && sr_q0;
  assign busy    = (state_q == SHIFT) || !empty;

endmodule
